rnn_cell_seq: RTL

- Parametrised sequential Elman RNN cell engine. Per timestep: h_t[j] = act(b_hh[j] + Σk W_hh[j][k]·h_{t-1}[k] + b_ih[j] + Σi x_t[i]·W_ih[j][i]).
- Binary input vectors arrive via an i_en/idata pull.
- Weights, biases and the timestep count are read from the shared banked parameter memory through msel/maddr.
- Each h_t[j] is written back to the result bank. Successor engine with configurable hidden size, input width and precision, and a runtime activation mode.

---
 rtl/rnn_pkg.sv | 47 ++++
 rtl/rnn_cell_seq_mac.sv | 71 +++++++
 rtl/rnn_cell_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// Shared definitions for the sequential Elman RNN cell engine:
// bank-select codes, FSM states, activation modes and width helpers.
package rnn_pkg;

    localparam logic [2:0] MSEL_WIH = 3'b000;
    localparam logic [2:0] MSEL_BHH = 3'b001;
    localparam logic [2:0] MSEL_WHH = 3'b010;
    localparam logic [2:0] MSEL_BIH = 3'b011;
    localparam logic [2:0] MSEL_CNT = 3'b100;
    localparam logic [2:0] MSEL_RES = 3'b101;

    localparam logic ACT_TANH = 1'b0;
    localparam logic ACT_RELU = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LDCNT,
        S_LDWAIT,
        S_FETCH,
        S_FLATCH,
        S_BHH,
        S_WIH,
        S_BIH,
        S_WHH,
        S_ROUND,
        S_WRITE
    } state_e;

    // Tags what kind of word is arriving on mdata_r this cycle.
    typedef enum logic [1:0] {
        PK_NONE,
        PK_BIAS,
        PK_WIH,
        PK_WHH
    } pk_e;

    // Accumulator wide enough that HID products plus IN_W+2 aligned
    // terms can never wrap.
    function automatic int acc_w(int dw, int hw, int hid, int in_w);
        return dw + hw + $clog2(hid + in_w) + 2;
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rnn_cell_seq_mac.sv
// Accumulator with clear / aligned-add / multiply-accumulate, followed by
// round-half-away-from-zero by FRAC bits and activation saturation.
// Ports: i_clr/i_add/i_mac control, i_d data word, i_h hidden operand,
// i_mode activation select, o_res saturated HW-bit result.
module rnn_mac
    import rnn_pkg::*;
#(
    parameter int DW    = 20,
    parameter int FRAC  = 16,
    parameter int HW    = FRAC + 2,
    parameter int ACC_W = 43
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_add,
    input  logic                 i_mac,
    input  logic signed [DW-1:0] i_d,
    input  logic signed [HW-1:0] i_h,
    input  logic                 i_mode,
    output logic signed [HW-1:0] o_res
);

    localparam logic [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC - 1);
    localparam logic [ACC_W-1:0] HALF_M1 = HALF - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] P_ONE = $signed(ACC_W'(1) << FRAC);
    localparam logic signed [ACC_W-1:0] N_ONE = -P_ONE;

    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DW+HW-1:0]   w_de;
    logic signed [DW+HW-1:0]   w_he;
    logic signed [DW+HW-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_prod_x;
    logic signed [ACC_W-1:0]   w_bias;
    logic        [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_q;
    logic signed [ACC_W-1:0]   w_lo;

    assign w_de     = {{HW{i_d[DW-1]}}, i_d};
    assign w_he     = {{DW{i_h[HW-1]}}, i_h};
    assign w_prod   = w_de * w_he;
    assign w_prod_x = {{(ACC_W-DW-HW){w_prod[DW+HW-1]}}, w_prod};
    // Biases and W_ih are Q.FRAC; products are Q.2FRAC.
    assign w_bias   = {{(ACC_W-DW-FRAC){i_d[DW-1]}}, i_d, {FRAC{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + w_bias;
        end else if (i_mac) begin
            r_acc <= r_acc + w_prod_x;
        end
    end

    // Adding half minus one for negatives makes the floor shift
    // round ties away from zero in both directions.
    assign w_sum = r_acc + (r_acc[ACC_W-1] ? HALF_M1 : HALF);
    assign w_q   = $signed(w_sum) >>> FRAC;
    assign w_lo  = (i_mode == ACT_RELU) ? '0 : N_ONE;

    always_comb begin
        o_res = w_q[HW-1:0];
        if (w_q > P_ONE) begin
            o_res = P_ONE[HW-1:0];
        end else if (w_q < w_lo) begin
            o_res = w_lo[HW-1:0];
        end
    end

endmodule

// File: rtl/rnn_cell_seq.sv
// Sequential Elman RNN cell: FSM, parameter-bank addressing, hidden
// state buffers and the idata pull. Ports: ready/act_mode start, busy,
// i_en/idata input pull, mce/msel/maddr/mdata_r/mdata_w memory port.
module rnn_cell_seq
    import rnn_pkg::*;
#(
    parameter int HID  = 64,
    parameter int IN_W = 32,
    parameter int DW   = 20,
    parameter int FRAC = 16,
    parameter int HW   = FRAC + 2,
    parameter int T_W  = 11,
    parameter int AW   = 17
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    input  logic            act_mode,
    output logic            busy,
    output logic            i_en,
    input  logic [IN_W-1:0] idata,
    output logic            mce,
    output logic [2:0]      msel,
    output logic [AW-1:0]   maddr,
    input  logic [DW-1:0]   mdata_r,
    output logic [DW-1:0]   mdata_w
);

    localparam int LH    = $clog2(HID);
    localparam int LIW   = $clog2(IN_W);
    localparam int KW    = max2(LH, LIW);
    localparam int ACC_W = acc_w(DW, HW, HID, IN_W);

    state_e    r_state;
    state_e    w_state_nxt;
    pk_e       r_pk;
    pk_e       w_pk;
    logic [LH-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   r_pidx;
    logic [T_W-1:0]  r_t;
    logic [T_W-1:0]  r_tcnt;
    logic [IN_W-1:0] r_x;
    logic            r_mode;
    logic signed [HW-1:0] r_hprev [HID];
    logic signed [HW-1:0] r_hnext [HID];

    logic signed [HW-1:0] w_res;
    logic [LIW-1:0]  w_xi;
    logic [LH-1:0]   w_hk;
    logic            w_k_last;
    logic            w_j_last;
    logic            w_t_last;
    logic            w_clr;
    logic            w_add;
    logic            w_mac;

    assign w_k_last = ((r_state == S_WIH) && (r_k == KW'(IN_W - 1))) ||
                      ((r_state == S_WHH) && (r_k == KW'(HID - 1)));
    assign w_j_last = (r_j == LH'(HID - 1));
    assign w_t_last = ((r_t + T_W'(1)) == r_tcnt);
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_pk        = PK_NONE;
        mce         = 1'b0;
        msel        = MSEL_CNT;
        maddr       = '0;
        i_en        = 1'b0;
        mdata_w     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (ready) w_state_nxt = S_LDCNT;
            end
            S_LDCNT: begin
                mce         = 1'b1;
                w_state_nxt = S_LDWAIT;
            end
            S_LDWAIT: begin
                if (mdata_r[T_W-1:0] == '0) w_state_nxt = S_IDLE;
                else                        w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                i_en        = 1'b1;
                w_state_nxt = S_FLATCH;
            end
            S_FLATCH: begin
                w_state_nxt = S_BHH;
            end
            S_BHH: begin
                mce         = 1'b1;
                msel        = MSEL_BHH;
                maddr       = AW'(r_j);
                w_pk        = PK_BIAS;
                w_state_nxt = S_WIH;
            end
            S_WIH: begin
                mce   = 1'b1;
                msel  = MSEL_WIH;
                maddr = AW'({r_j, r_k[LIW-1:0]});
                w_pk  = PK_WIH;
                if (w_k_last) w_state_nxt = S_BIH;
            end
            S_BIH: begin
                mce         = 1'b1;
                msel        = MSEL_BIH;
                maddr       = AW'(r_j);
                w_pk        = PK_BIAS;
                w_state_nxt = S_WHH;
            end
            S_WHH: begin
                mce   = 1'b1;
                msel  = MSEL_WHH;
                maddr = AW'({r_j, r_k[LH-1:0]});
                w_pk  = PK_WHH;
                if (w_k_last) w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mce     = 1'b1;
                msel    = MSEL_RES;
                maddr   = AW'({r_t, r_j});
                mdata_w = {{(DW-HW){w_res[HW-1]}}, w_res};
                if (!w_j_last)     w_state_nxt = S_BHH;
                else if (w_t_last) w_state_nxt = S_IDLE;
                else               w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pk    <= PK_NONE;
            r_j     <= '0;
            r_k     <= '0;
            r_pidx  <= '0;
            r_t     <= '0;
            r_tcnt  <= '0;
            r_x     <= '0;
            r_mode  <= ACT_TANH;
            for (int k = 0; k < HID; k++) begin
                r_hprev[k] <= '0;
                r_hnext[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pk    <= w_pk;
            r_pidx  <= r_k;
            if (((r_state == S_WIH) || (r_state == S_WHH)) && !w_k_last) begin
                r_k <= r_k + KW'(1);
            end else begin
                r_k <= '0;
            end
            if ((r_state == S_IDLE) && ready) begin
                r_mode <= act_mode;
                r_t    <= '0;
                for (int k = 0; k < HID; k++) begin
                    r_hprev[k] <= '0;
                    r_hnext[k] <= '0;
                end
            end
            if (r_state == S_LDWAIT) begin
                r_tcnt <= mdata_r[T_W-1:0];
            end
            if (r_state == S_FLATCH) begin
                r_x <= idata;
                r_j <= '0;
            end
            if (r_state == S_WRITE) begin
                r_hnext[r_j] <= w_res;
                if (w_j_last) begin
                    // Last unit's result is still in flight; forward it.
                    for (int k = 0; k < HID; k++) begin
                        r_hprev[k] <= (k == HID - 1) ? w_res : r_hnext[k];
                    end
                    r_t <= r_t + T_W'(1);
                end else begin
                    r_j <= r_j + LH'(1);
                end
            end
        end
    end

    // r_pidx is the index of the read issued last cycle, whose data
    // is on mdata_r now.
    assign w_xi  = r_pidx[LIW-1:0];
    assign w_hk  = r_pidx[LH-1:0];
    assign w_clr = (r_state == S_BHH);
    assign w_add = (r_pk == PK_BIAS) || ((r_pk == PK_WIH) && r_x[w_xi]);
    assign w_mac = (r_pk == PK_WHH);

    rnn_mac #(
        .DW    (DW),
        .FRAC  (FRAC),
        .HW    (HW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_add  (w_add),
        .i_mac  (w_mac),
        .i_d    (mdata_r),
        .i_h    (r_hprev[w_hk]),
        .i_mode (r_mode),
        .o_res  (w_res)
    );

endmodule
